axi2mem_rd_cmd_gen: RTL and testbench

- Read-address stage of the axi2mem bridge; sits directly upstream of the TCDM read interface.
- Accepts one AXI4 AR burst at a time and expands it into per-beat TCDM read commands: address, ID, last flag.
- Commands are handed out over a req/gnt handshake; burst address arithmetic (FIXED/INCR/WRAP) lives here, so the downstream stage only ever sees single-word commands.

---
 rtl/axi2mem_rd_cmd_gen_if.sv | 31 +++
 rtl/axi2mem_rd_cmd_gen.sv | 104 ++++++++++
 tb/tb_axi2mem_rd_cmd_gen.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/axi2mem_rd_cmd_gen_if.sv
// AR-burst request and per-beat TCDM read-command signals of the axi2mem read-address stage.
// slave: command-generator view; master: upstream AR source plus downstream beat consumer.
interface axi2mem_rd_cmd_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 6,
  parameter int LEN_WIDTH  = 8
);
  logic                  ar_valid_i;
  logic                  ar_ready_o;
  logic [ADDR_WIDTH-1:0] ar_addr_i;
  logic [LEN_WIDTH-1:0]  ar_len_i;
  logic [2:0]            ar_size_i;
  logic [1:0]            ar_burst_i;
  logic [ID_WIDTH-1:0]   ar_id_i;

  logic                  trans_req_o;
  logic                  trans_gnt_i;
  logic [ADDR_WIDTH-1:0] trans_add_o;
  logic [ID_WIDTH-1:0]   trans_id_o;
  logic                  trans_last_o;

  modport slave (
    input  ar_valid_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_id_i, trans_gnt_i,
    output ar_ready_o, trans_req_o, trans_add_o, trans_id_o, trans_last_o
  );

  modport master (
    output ar_valid_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_id_i, trans_gnt_i,
    input  ar_ready_o, trans_req_o, trans_add_o, trans_id_o, trans_last_o
  );
endinterface

// File: rtl/axi2mem_rd_cmd_gen.sv
// Expands one AXI4 AR burst (FIXED/INCR/WRAP) into single-word TCDM read commands over req/gnt.
// AXI2MEM_RD_CMD_BACK2BACK_EN: accept the next AR on the last-beat grant for zero-bubble bursts.
module axi2mem_rd_cmd_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 6,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  axi2mem_rd_cmd_gen_if.slave   bus,
  output logic                  busy_o
);

  typedef enum logic {IDLE, BURST} state_e;
  typedef enum logic [1:0] {MODE_FIXED, MODE_INCR, MODE_WRAP} mode_e;

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_ld;
  logic [ADDR_WIDTH-1:0] addr_q, mask_q, addr_next, incr, wrap_bytes;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [1:0]            size_q, size_ld;
  logic                  ar_ready, ar_hs, beat_gnt, last_beat, wrap_len_ok;

  // Load-side decode of the incoming AR beat geometry
  always_comb begin
    size_ld     = (bus.ar_size_i > 3'd2) ? 2'd2 : bus.ar_size_i[1:0];
    wrap_len_ok = (bus.ar_len_i == LEN_WIDTH'(1)) || (bus.ar_len_i == LEN_WIDTH'(3)) ||
                  (bus.ar_len_i == LEN_WIDTH'(7)) || (bus.ar_len_i == LEN_WIDTH'(15));
    wrap_bytes  = (ADDR_WIDTH'(bus.ar_len_i) + ADDR_WIDTH'(1)) << size_ld;
    if (bus.ar_burst_i == 2'b00)
      mode_ld = MODE_FIXED;
    else if (bus.ar_burst_i == 2'b10 && wrap_len_ok)
      mode_ld = MODE_WRAP;
    else
      mode_ld = MODE_INCR;
  end

  always_comb begin
    incr = ADDR_WIDTH'(1) << size_q;
    case (mode_q)
      MODE_FIXED: addr_next = addr_q;
      MODE_WRAP:  addr_next = (addr_q & ~mask_q) | ((addr_q + incr) & mask_q);
      default:    addr_next = (addr_q & ~(incr - ADDR_WIDTH'(1))) + incr;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ar_ready  = 1'b0;
    last_beat = (state_q == BURST) && (cnt_q == '0);
    beat_gnt  = (state_q == BURST) && bus.trans_gnt_i;
    case (state_q)
      IDLE: begin
        ar_ready = 1'b1;
        if (bus.ar_valid_i) state_d = BURST;
      end
      BURST: begin
`ifdef AXI2MEM_RD_CMD_BACK2BACK_EN
        ar_ready = last_beat && bus.trans_gnt_i;
`endif
        if (last_beat && bus.trans_gnt_i && !(bus.ar_valid_i && ar_ready)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) ar_ready = 1'b0;
    ar_hs = bus.ar_valid_i && ar_ready;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A handshake overrides the advance: in back-to-back mode it lands on the old burst's final grant
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
      id_q   <= '0;
      size_q <= '0;
      mode_q <= MODE_INCR;
    end else if (ar_hs) begin
      addr_q <= bus.ar_addr_i;
      mask_q <= wrap_bytes - ADDR_WIDTH'(1);
      cnt_q  <= bus.ar_len_i;
      id_q   <= bus.ar_id_i;
      size_q <= size_ld;
      mode_q <= mode_ld;
    end else if (beat_gnt && !last_beat) begin
      addr_q <= addr_next;
      cnt_q  <= cnt_q - LEN_WIDTH'(1);
    end
  end

  assign bus.ar_ready_o   = ar_ready;
  assign bus.trans_req_o  = (state_q == BURST);
  assign bus.trans_add_o  = addr_q;
  assign bus.trans_id_o   = id_q;
  assign bus.trans_last_o = last_beat;
  assign busy_o           = (state_q == BURST);

endmodule

// File: tb/tb_axi2mem_rd_cmd_gen.sv
// Directed bench for axi2mem_rd_cmd_gen: burst address sequences, stalls, reset abort, burst spacing.
module tb_axi2mem_rd_cmd_gen;
  localparam int AW = 32;
  localparam int IW = 6;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_checks = 0;
  int   n_pass   = 0;

  axi2mem_rd_cmd_gen_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) bus ();

  axi2mem_rd_cmd_gen #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus.slave),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Present one AR for a single edge; caller is 1 time unit after an edge with the DUT idle.
  task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [5:0] id);
    bus.ar_addr_i  = addr;
    bus.ar_len_i   = len;
    bus.ar_size_i  = size;
    bus.ar_burst_i = burst;
    bus.ar_id_i    = id;
    bus.ar_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.ar_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.ar_ready_o !== 1'b0) $display("FAIL rst_ar_ready: got %b want 0", bus.ar_ready_o); else n_pass++;
    n_checks++; if (bus.trans_req_o !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.trans_req_o); else n_pass++;
    n_checks++; if (bus.trans_add_o !== 32'h0) $display("FAIL rst_add: got %h want 0", bus.trans_add_o); else n_pass++;
    n_checks++; if (bus.trans_id_o !== 6'h0) $display("FAIL rst_id: got %h want 0", bus.trans_id_o); else n_pass++;
    n_checks++; if (bus.trans_last_o !== 1'b0) $display("FAIL rst_last: got %b want 0", bus.trans_last_o); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.ar_ready_o !== 1'b1) $display("FAIL idle_ar_ready: got %b want 1", bus.ar_ready_o); else n_pass++;
  endtask

  task automatic test_incr;
    logic [31:0] exp [4];
    exp[0] = 32'h1000; exp[1] = 32'h1004; exp[2] = 32'h1008; exp[3] = 32'h100C;
    bus.trans_gnt_i = 1'b1;
    n_checks++; if (bus.trans_req_o !== 1'b0) $display("FAIL incr_pre_req: got %b want 0", bus.trans_req_o); else n_pass++;
    ar_issue(32'h1000, 8'd3, 3'd2, 2'b01, 6'd5);
    for (int b = 0; b < 4; b++) begin
      n_checks++; if (bus.trans_req_o !== 1'b1) $display("FAIL incr_req beat %0d: got %b want 1", b, bus.trans_req_o); else n_pass++;
      n_checks++; if (bus.trans_add_o !== exp[b]) $display("FAIL incr_add beat %0d: got %h want %h", b, bus.trans_add_o, exp[b]); else n_pass++;
      n_checks++; if (bus.trans_last_o !== (b == 3)) $display("FAIL incr_last beat %0d: got %b want %b", b, bus.trans_last_o, (b == 3)); else n_pass++;
      n_checks++; if (bus.trans_id_o !== 6'd5) $display("FAIL incr_id beat %0d: got %h want 5", b, bus.trans_id_o); else n_pass++;
      n_checks++; if (bus.ar_ready_o !== 1'b0) $display("FAIL incr_ar_ready beat %0d: got %b want 0", b, bus.ar_ready_o); else n_pass++;
      @(posedge clk); #1;
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL incr_busy_end: got %b want 0", busy); else n_pass++;
    n_checks++; if (bus.trans_req_o !== 1'b0) $display("FAIL incr_req_end: got %b want 0", bus.trans_req_o); else n_pass++;
  endtask

  task automatic test_wrap;
    logic [31:0] exp [4];
    exp[0] = 32'h2008; exp[1] = 32'h200C; exp[2] = 32'h2000; exp[3] = 32'h2004;
    bus.trans_gnt_i = 1'b1;
    ar_issue(32'h2008, 8'd3, 3'd2, 2'b10, 6'd7);
    for (int b = 0; b < 4; b++) begin
      n_checks++; if (bus.trans_add_o !== exp[b]) $display("FAIL wrap_add beat %0d: got %h want %h", b, bus.trans_add_o, exp[b]); else n_pass++;
      n_checks++; if (bus.trans_last_o !== (b == 3)) $display("FAIL wrap_last beat %0d: got %b want %b", b, bus.trans_last_o, (b == 3)); else n_pass++;
      @(posedge clk); #1;
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL wrap_busy_end: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_fixed_stall;
    logic gnt_pat [5];
    int   b;
    gnt_pat[0] = 1'b1; gnt_pat[1] = 1'b0; gnt_pat[2] = 1'b1; gnt_pat[3] = 1'b0; gnt_pat[4] = 1'b1;
    bus.trans_gnt_i = 1'b0;
    ar_issue(32'h30, 8'd2, 3'd2, 2'b00, 6'd11);
    b = 0;
    for (int c = 0; c < 5; c++) begin
      bus.trans_gnt_i = gnt_pat[c];
      n_checks++; if (bus.trans_req_o !== 1'b1) $display("FAIL fixed_req cyc %0d: got %b want 1", c, bus.trans_req_o); else n_pass++;
      n_checks++; if (bus.trans_add_o !== 32'h30) $display("FAIL fixed_add cyc %0d: got %h want 30", c, bus.trans_add_o); else n_pass++;
      n_checks++; if (bus.trans_last_o !== (b == 2)) $display("FAIL fixed_last cyc %0d: got %b want %b", c, bus.trans_last_o, (b == 2)); else n_pass++;
      n_checks++; if (bus.trans_id_o !== 6'd11) $display("FAIL fixed_id cyc %0d: got %h want 11", c, bus.trans_id_o); else n_pass++;
      if (gnt_pat[c]) b++;
      @(posedge clk); #1;
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL fixed_busy_end: got %b want 0", busy); else n_pass++;
    bus.trans_gnt_i = 1'b1;
  endtask

  task automatic test_size_and_types;
    logic [31:0] c_addr  [4];
    logic [7:0]  c_len   [4];
    logic [2:0]  c_size  [4];
    logic [1:0]  c_burst [4];
    logic [31:0] exp [4][3];
    c_addr[0] = 32'h1003; c_len[0] = 8'd1; c_size[0] = 3'd2; c_burst[0] = 2'b01;
    exp[0][0] = 32'h1003; exp[0][1] = 32'h1004; exp[0][2] = 32'h0;
    c_addr[1] = 32'h0;    c_len[1] = 8'd1; c_size[1] = 3'd3; c_burst[1] = 2'b01;
    exp[1][0] = 32'h0;    exp[1][1] = 32'h4;    exp[1][2] = 32'h0;
    c_addr[2] = 32'h10;   c_len[2] = 8'd1; c_size[2] = 3'd2; c_burst[2] = 2'b11;
    exp[2][0] = 32'h10;   exp[2][1] = 32'h14;   exp[2][2] = 32'h0;
    c_addr[3] = 32'h2008; c_len[3] = 8'd2; c_size[3] = 3'd2; c_burst[3] = 2'b10;
    exp[3][0] = 32'h2008; exp[3][1] = 32'h200C; exp[3][2] = 32'h2010;
    bus.trans_gnt_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      ar_issue(c_addr[t], c_len[t], c_size[t], c_burst[t], 6'(t));
      for (int b = 0; b <= int'(c_len[t]); b++) begin
        n_checks++; if (bus.trans_add_o !== exp[t][b]) $display("FAIL types_add case %0d beat %0d: got %h want %h", t, b, bus.trans_add_o, exp[t][b]); else n_pass++;
        n_checks++; if (bus.trans_last_o !== (b == int'(c_len[t]))) $display("FAIL types_last case %0d beat %0d: got %b", t, b, bus.trans_last_o); else n_pass++;
        @(posedge clk); #1;
      end
      n_checks++; if (busy !== 1'b0) $display("FAIL types_busy_end case %0d: got %b want 0", t, busy); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_burst;
    bus.trans_gnt_i = 1'b1;
    ar_issue(32'h4000, 8'd7, 3'd2, 2'b01, 6'd3);
    n_checks++; if (bus.trans_add_o !== 32'h4000) $display("FAIL rmid_beat0: got %h want 4000", bus.trans_add_o); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.trans_add_o !== 32'h4004) $display("FAIL rmid_beat1: got %h want 4004", bus.trans_add_o); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.trans_req_o !== 1'b0) $display("FAIL rmid_req: got %b want 0", bus.trans_req_o); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (bus.ar_ready_o !== 1'b0) $display("FAIL rmid_ar_ready_in_rst: got %b want 0", bus.ar_ready_o); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.ar_ready_o !== 1'b1) $display("FAIL rmid_ar_ready_after: got %b want 1", bus.ar_ready_o); else n_pass++;
    ar_issue(32'h50, 8'd0, 3'd2, 2'b01, 6'd9);
    n_checks++; if (bus.trans_req_o !== 1'b1) $display("FAIL rmid_single_req: got %b want 1", bus.trans_req_o); else n_pass++;
    n_checks++; if (bus.trans_add_o !== 32'h50) $display("FAIL rmid_single_add: got %h want 50", bus.trans_add_o); else n_pass++;
    n_checks++; if (bus.trans_last_o !== 1'b1) $display("FAIL rmid_single_last: got %b want 1", bus.trans_last_o); else n_pass++;
    n_checks++; if (bus.trans_id_o !== 6'd9) $display("FAIL rmid_single_id: got %h want 9", bus.trans_id_o); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_single_busy_end: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int   gap;
    logic found;
    logic hs;
    logic exp_rdy;
    int   exp_gap;
`ifdef AXI2MEM_RD_CMD_BACK2BACK_EN
    exp_rdy = 1'b1; exp_gap = 0;
`else
    exp_rdy = 1'b0; exp_gap = 1;
`endif
    bus.trans_gnt_i = 1'b1;
    ar_issue(32'h100, 8'd0, 3'd2, 2'b01, 6'd1);
    n_checks++; if (bus.trans_add_o !== 32'h100) $display("FAIL b2b_a_add: got %h want 100", bus.trans_add_o); else n_pass++;
    bus.ar_addr_i  = 32'h200;
    bus.ar_len_i   = 8'd0;
    bus.ar_size_i  = 3'd2;
    bus.ar_burst_i = 2'b01;
    bus.ar_id_i    = 6'd2;
    bus.ar_valid_i = 1'b1;
    #1;
    n_checks++; if (bus.ar_ready_o !== exp_rdy) $display("FAIL b2b_ar_ready_last: got %b want %b", bus.ar_ready_o, exp_rdy); else n_pass++;
    gap = 0;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      #1;
      hs = bus.ar_valid_i && bus.ar_ready_o;
      @(posedge clk); #1;
      if (hs) bus.ar_valid_i = 1'b0;
      if (bus.trans_req_o && bus.trans_add_o == 32'h200) found = 1'b1;
      else if (!bus.trans_req_o) gap++;
    end
    bus.ar_valid_i = 1'b0;
    n_checks++; if (found !== 1'b1) $display("FAIL b2b_b_seen: got %b want 1", found); else n_pass++;
    n_checks++; if (gap != exp_gap) $display("FAIL b2b_gap: got %0d want %0d", gap, exp_gap); else n_pass++;
    n_checks++; if (bus.trans_id_o !== 6'd2) $display("FAIL b2b_b_id: got %h want 2", bus.trans_id_o); else n_pass++;
    n_checks++; if (bus.trans_last_o !== 1'b1) $display("FAIL b2b_b_last: got %b want 1", bus.trans_last_o); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_busy_end: got %b want 0", busy); else n_pass++;
  endtask

  initial begin
    rst            = 1'b1;
    bus.ar_valid_i = 1'b0;
    bus.ar_addr_i  = '0;
    bus.ar_len_i   = '0;
    bus.ar_size_i  = '0;
    bus.ar_burst_i = '0;
    bus.ar_id_i    = '0;
    bus.trans_gnt_i = 1'b0;
    test_reset();
    test_incr();
    test_wrap();
    test_fixed_stall();
    test_size_and_types();
    test_reset_mid_burst();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
